// File: rtl/load_buffer_tracker_if.sv
// Load buffer tracker bus interface.
// Bundles the allocation handshake, the dcache response path, the flush
// strobe and the status outputs of load_buffer_tracker.
//   master : load unit side (drives flush, requests and dcache responses)
//   slave  : tracker side (drives ready/tid, forwarded response, status)
// Parameters must match the ones given to the tracker instance.
interface load_buffer_tracker_if #(
    parameter int unsigned TidWidth     = 2,
    parameter int unsigned TransIdWidth = 2,
    parameter int unsigned CountWidth   = 2
);
    logic                    flush_i;

    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [TransIdWidth-1:0] req_trans_id_i;
    logic [1:0]              req_offset_i;
    logic [1:0]              req_size_i;
    logic                    req_signed_i;
    logic [TidWidth-1:0]     req_tid_o;

    logic                    rsp_valid_i;
    logic [TidWidth-1:0]     rsp_tid_i;
    logic                    rsp_valid_o;
    logic [TransIdWidth-1:0] rsp_trans_id_o;
    logic [1:0]              rsp_offset_o;
    logic [1:0]              rsp_size_o;
    logic                    rsp_signed_o;

    logic                    empty_o;
    logic [CountWidth-1:0]   count_o;
    logic                    err_o;

    modport master (
        output flush_i,
        output req_valid_i, req_trans_id_i, req_offset_i, req_size_i, req_signed_i,
        input  req_ready_o, req_tid_o,
        output rsp_valid_i, rsp_tid_i,
        input  rsp_valid_o, rsp_trans_id_o, rsp_offset_o, rsp_size_o, rsp_signed_o,
        input  empty_o, count_o, err_o
    );

    modport slave (
        input  flush_i,
        input  req_valid_i, req_trans_id_i, req_offset_i, req_size_i, req_signed_i,
        output req_ready_o, req_tid_o,
        input  rsp_valid_i, rsp_tid_i,
        output rsp_valid_o, rsp_trans_id_o, rsp_offset_o, rsp_size_o, rsp_signed_o,
        output empty_o, count_o, err_o
    );
endinterface

// File: rtl/load_buffer_tracker.sv
// Load buffer tracker.
// Keeps one slot per outstanding dcache load. A slot is allocated when the
// load is issued (its index becomes the memory transaction id) and released
// when the dcache response with that id returns. Flushed loads stay allocated
// but are marked killed so their late response is swallowed, not forwarded.
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_ni : synchronous active-low reset, clears all slots
//   bus    : slave modport of load_buffer_tracker_if (request, response,
//            flush and status signals)
module load_buffer_tracker #(
    parameter int unsigned NrEntries    = 2,
    parameter int unsigned TidWidth     = 2,
    parameter int unsigned TransIdWidth = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    load_buffer_tracker_if.slave  bus
);
    localparam int unsigned CountWidth = $clog2(NrEntries + 1);
    localparam int unsigned IdxWidth   = (NrEntries > 1) ? $clog2(NrEntries) : 1;

    // slot state
    logic [NrEntries-1:0]    valid_q;
    logic [NrEntries-1:0]    killed_q;
    logic [TransIdWidth-1:0] trans_id_q [NrEntries];
    logic [1:0]              offset_q   [NrEntries];
    logic [1:0]              size_q     [NrEntries];
    logic                    signed_q   [NrEntries];

    logic                    free_any;
    logic [IdxWidth-1:0]     free_idx;
    logic                    alloc;

    logic                    hit_valid;
    logic                    hit_killed;
    logic [IdxWidth-1:0]     hit_idx;
    logic                    rsp_free;

    logic [CountWidth-1:0]   count;

    // lowest-index free slot; scanning downwards leaves the lowest one last
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NrEntries - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IdxWidth'(i);
            end
        end
    end

    // Ready looks only at registered state, so a slot released by a response
    // this cycle cannot be handed out again until the next cycle.
    assign bus.req_ready_o = !bus.flush_i && free_any;
    assign bus.req_tid_o   = TidWidth'(free_idx);
    assign alloc           = bus.req_valid_i && bus.req_ready_o;

    // Decode the response tid. An id outside the slot range never matches,
    // which makes it look like a response to an invalid slot.
    always_comb begin
        hit_valid  = 1'b0;
        hit_killed = 1'b0;
        hit_idx    = '0;
        for (int i = 0; i < NrEntries; i++) begin
            if (bus.rsp_tid_i == TidWidth'(i)) begin
                hit_valid  = valid_q[i];
                hit_killed = killed_q[i];
                hit_idx    = IdxWidth'(i);
            end
        end
    end

    // A matching response always releases its slot, killed or not. A flush in
    // the same cycle suppresses forwarding even for a live slot.
    assign rsp_free           = bus.rsp_valid_i && hit_valid;
    assign bus.rsp_valid_o    = rsp_free && !hit_killed && !bus.flush_i;
    assign bus.err_o          = bus.rsp_valid_i && !hit_valid;
    assign bus.rsp_trans_id_o = trans_id_q[hit_idx];
    assign bus.rsp_offset_o   = offset_q[hit_idx];
    assign bus.rsp_size_o     = size_q[hit_idx];
    assign bus.rsp_signed_o   = signed_q[hit_idx];

    // Allocation and release can never target the same slot: allocation only
    // picks a slot that is currently invalid, release only a valid one.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            killed_q <= '0;
        end else begin
            for (int i = 0; i < NrEntries; i++) begin
                if (bus.flush_i && valid_q[i]) begin
                    killed_q[i] <= 1'b1;
                end
                if (rsp_free && (hit_idx == IdxWidth'(i))) begin
                    valid_q[i] <= 1'b0;
                end
                if (alloc && (free_idx == IdxWidth'(i))) begin
                    valid_q[i]  <= 1'b1;
                    killed_q[i] <= 1'b0;
                end
            end
        end
    end

    // metadata is only meaningful while the slot is valid, so it needs no reset
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            trans_id_q[free_idx] <= bus.req_trans_id_i;
            offset_q[free_idx]   <= bus.req_offset_i;
            size_q[free_idx]     <= bus.req_size_i;
            signed_q[free_idx]   <= bus.req_signed_i;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NrEntries; i++) begin
            if (valid_q[i]) begin
                count = count + CountWidth'(1);
            end
        end
    end

    assign bus.count_o = count;
    assign bus.empty_o = ~|valid_q;

endmodule

// File: tb/tb_load_buffer_tracker.sv
// Testbench for load_buffer_tracker: directed scenarios followed by random
// traffic, all outputs compared each cycle against a slot-list model.
module tb_load_buffer_tracker;
    localparam int N = 2;

    logic clk;
    logic rst_n;

    load_buffer_tracker_if #(.TidWidth(2), .TransIdWidth(2), .CountWidth(2)) bus ();

    load_buffer_tracker #(.NrEntries(N), .TidWidth(2), .TransIdWidth(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: one record per slot
    int m_valid  [N];
    int m_killed [N];
    int m_trans  [N];
    int m_off    [N];
    int m_size   [N];
    int m_sgn    [N];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_valid[i];
        return c;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < N; i++) if (m_valid[i] == 0) return i;
        return -1;
    endfunction

    function automatic int m_hit();
        int t = int'(bus.rsp_tid_i);
        return (bus.rsp_valid_i && t < N && m_valid[t] == 1) ? 1 : 0;
    endfunction

    task automatic drive(input bit fl, input bit rv, input int tr, input int off,
                         input int sz, input bit sg, input bit pv, input int ptid);
        @(negedge clk);
        bus.flush_i        = fl;
        bus.req_valid_i    = rv;
        bus.req_trans_id_i = 2'(tr);
        bus.req_offset_i   = 2'(off);
        bus.req_size_i     = 2'(sz);
        bus.req_signed_i   = sg;
        bus.rsp_valid_i    = pv;
        bus.rsp_tid_i      = 2'(ptid);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // compare every output against what the model says for the current inputs
    task automatic check_model();
        int ff  = m_first_free();
        int rdy = (!bus.flush_i && ff >= 0) ? 1 : 0;
        int hit = m_hit();
        int t   = int'(bus.rsp_tid_i);
        int fwd = (hit == 1 && m_killed[t] == 0 && !bus.flush_i) ? 1 : 0;
        check_val("ready", int'(bus.req_ready_o), rdy);
        if (ff >= 0) check_val("req_tid", int'(bus.req_tid_o), ff);
        check_val("rsp_valid", int'(bus.rsp_valid_o), fwd);
        check_val("err", int'(bus.err_o), (bus.rsp_valid_i && hit == 0) ? 1 : 0);
        check_val("count", int'(bus.count_o), m_count());
        check_val("empty", int'(bus.empty_o), (m_count() == 0) ? 1 : 0);
        if (fwd == 1) begin
            check_val("rsp_trans_id", int'(bus.rsp_trans_id_o), m_trans[t]);
            check_val("rsp_offset", int'(bus.rsp_offset_o), m_off[t]);
            check_val("rsp_size", int'(bus.rsp_size_o), m_size[t]);
            check_val("rsp_signed", int'(bus.rsp_signed_o), m_sgn[t]);
        end
    endtask

    // advance one clock and apply the same edge to the model
    task automatic tick();
        int ff  = m_first_free();
        int hit = m_hit();
        int t   = int'(bus.rsp_tid_i);
        bit fl  = bus.flush_i;
        bit rv  = bus.req_valid_i;
        bit rst = rst_n;
        int tr  = int'(bus.req_trans_id_i);
        int off = int'(bus.req_offset_i);
        int sz  = int'(bus.req_size_i);
        int sg  = int'(bus.req_signed_i);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i]  = 0;
                m_killed[i] = 0;
            end
        end else begin
            if (fl) for (int i = 0; i < N; i++) if (m_valid[i] == 1) m_killed[i] = 1;
            if (hit == 1) m_valid[t] = 0;
            if (rv && !fl && ff >= 0) begin
                m_valid[ff]  = 1;
                m_killed[ff] = 0;
                m_trans[ff]  = tr;
                m_off[ff]    = off;
                m_size[ff]   = sz;
                m_sgn[ff]    = sg;
            end
        end
    endtask

    task automatic step(input bit fl, input bit rv, input int tr, input int off,
                        input int sz, input bit sg, input bit pv, input int ptid);
        drive(fl, rv, tr, off, sz, sg, pv, ptid);
        check_model();
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_killed[i] = 0; m_trans[i] = 0;
            m_off[i] = 0; m_size[i] = 0; m_sgn[i] = 0;
        end
        idle();
        do_reset();

        // reset state
        idle();
        check_model();
        check_val("rst_ready", int'(bus.req_ready_o), 1);
        check_val("rst_tid", int'(bus.req_tid_o), 0);
        check_val("rst_empty", int'(bus.empty_o), 1);
        check_val("rst_count", int'(bus.count_o), 0);
        tick();

        // two requests fill the buffer, a third stalls
        drive(0, 1, 1, 0, 2, 0, 0, 0); check_model();
        check_val("d35_tid_a", int'(bus.req_tid_o), 0); tick();
        drive(0, 1, 3, 1, 1, 1, 0, 0); check_model();
        check_val("d35_tid_b", int'(bus.req_tid_o), 1); tick();
        drive(0, 1, 2, 0, 0, 0, 0, 0); check_model();
        check_val("d35_ready", int'(bus.req_ready_o), 0);
        check_val("d35_count", int'(bus.count_o), 2); tick();

        // response on tid 1 while full; freed slot only reusable next cycle
        drive(0, 1, 2, 0, 0, 0, 1, 1); check_model();
        check_val("d36_rsp_valid", int'(bus.rsp_valid_o), 1);
        check_val("d36_trans_id", int'(bus.rsp_trans_id_o), 3);
        check_val("d36_ready_same", int'(bus.req_ready_o), 0); tick();
        idle(); check_model();
        check_val("d36_ready_next", int'(bus.req_ready_o), 1);
        check_val("d36_tid_next", int'(bus.req_tid_o), 1); tick();

        // flush kills slot 0; its late response is swallowed without error
        drive(1, 1, 0, 0, 0, 0, 0, 0); check_model();
        check_val("d37_ready", int'(bus.req_ready_o), 0); tick();
        idle(); check_model();
        check_val("d37_count_killed", int'(bus.count_o), 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0); check_model();
        check_val("d37_rsp_valid", int'(bus.rsp_valid_o), 0);
        check_val("d37_err", int'(bus.err_o), 0); tick();
        idle(); check_model();
        check_val("d37_empty", int'(bus.empty_o), 1); tick();

        // response to an empty slot
        drive(0, 0, 0, 0, 0, 0, 1, 1); check_model();
        check_val("d38_err", int'(bus.err_o), 1); tick();
        idle(); check_model();
        check_val("d38_err_gone", int'(bus.err_o), 0);
        check_val("d38_count", int'(bus.count_o), 0); tick();

        // allocate slot 1 while slot 0 responds
        step(0, 1, 2, 0, 2, 0, 0, 0);
        drive(0, 1, 1, 2, 1, 1, 1, 0); check_model();
        check_val("d39_tid", int'(bus.req_tid_o), 1); tick();
        idle(); check_model();
        check_val("d39_count", int'(bus.count_o), 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1); check_model();
        check_val("d39_trans", int'(bus.rsp_trans_id_o), 1);
        check_val("d39_off", int'(bus.rsp_offset_o), 2);
        check_val("d39_size", int'(bus.rsp_size_o), 1);
        check_val("d39_sgn", int'(bus.rsp_signed_o), 1); tick();

        // reset with both slots valid; later responses are protocol errors
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        do_reset();
        idle(); check_model();
        check_val("d40_empty", int'(bus.empty_o), 1);
        check_val("d40_count", int'(bus.count_o), 0);
        check_val("d40_tid", int'(bus.req_tid_o), 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0); check_model();
        check_val("d34_err", int'(bus.err_o), 1); tick();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) == 0,
                     $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)),
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) != 0,
                     int'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
